// File: rtl/cq_credit_rx_buf.sv
// cq_credit_rx_buf: receive buffer for a credit-flowed PCIe CQ stream.
// Incoming beats carry no ready signal. The sender may only send a beat when it
// holds a credit. This block returns one credit for every entry its user-side
// consumer frees, and it only does so while the link is up.
// Optional feature: define CQ_RXBUF_PKT_CNT_EN to add a 32-bit count of
// completed packets (pkt_cnt).
module cq_credit_rx_buf #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          user_clk,
  input  logic          user_reset_n,
  input  logic          link_up,
  input  logic [511:0]  s_axis_cq_tdata,
  input  logic [228:0]  s_axis_cq_tuser,
  input  logic          s_axis_cq_tlast,
  input  logic [15:0]   s_axis_cq_tkeep,
  input  logic          s_axis_cq_tvalid,
  output logic          s_axis_cq_credit,
  output logic [511:0]  m_axis_cq_tdata,
  output logic [228:0]  m_axis_cq_tuser,
  output logic          m_axis_cq_tlast,
  output logic [15:0]   m_axis_cq_tkeep,
  output logic          m_axis_cq_tvalid,
  input  logic          m_axis_cq_tready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow_err
`ifdef CQ_RXBUF_PKT_CNT_EN
  ,
  output logic [31:0]   pkt_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [LW-1:0] CRED_ONE = LW'(1);

  typedef struct packed {
    logic [511:0] tdata;
    logic [228:0] tuser;
    logic         tlast;
    logic [15:0]  tkeep;
  } beat_t;

  typedef enum logic {WAIT_LINK, ACTIVE} state_t;

  beat_t         mem [DEPTH];
  beat_t         head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [LW-1:0] credit_pend;
  logic          credit_issue;
  state_t        state_q, state_d;

  // The pointers are log2(DEPTH) index bits plus a wrap bit. When the indices
  // are equal, the FIFO is full if the wrap bits differ and empty if they match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && m_axis_cq_tready;
  // When the FIFO is full, a pop in the same cycle frees the slot that this push fills.
  assign push  = s_axis_cq_tvalid && (!full || pop);

  assign head             = mem[rd_ptr[AW-1:0]];
  assign m_axis_cq_tvalid = !empty;
  // The data outputs are forced to zero while the FIFO is empty. This keeps
  // them at zero through reset, even though the storage array is not reset.
  assign m_axis_cq_tdata  = empty ? '0 : head.tdata;
  assign m_axis_cq_tuser  = empty ? '0 : head.tuser;
  assign m_axis_cq_tlast  = empty ? 1'b0 : head.tlast;
  assign m_axis_cq_tkeep  = empty ? '0 : head.tkeep;
  assign fifo_level       = LW'(wr_ptr - rd_ptr);

  // A credit is issued in a cycle when the link was up and at least one credit was owed.
  assign credit_issue = (state_q == ACTIVE) && (credit_pend != '0);

  // Storage array: writes only.
  // NOTE: the data array has no reset. The pointers alone define which entries
  // are valid, and leaving out the reset keeps the array in plain RAM/flops.
  always_ff @(posedge user_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{tdata: s_axis_cq_tdata, tuser: s_axis_cq_tuser,
                                       tlast: s_axis_cq_tlast, tkeep: s_axis_cq_tkeep};
  end

  // Pointers, sticky overflow flag, credit accounting and the registered credit pulse.
  // NOTE: every sequential block uses non-blocking assignments only. Each
  // register then samples the values from before the clock edge, whatever
  // order the statements are written in.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      overflow_err     <= 1'b0;
      credit_pend      <= LW'(DEPTH);
      s_axis_cq_credit <= 1'b0;
      state_q          <= WAIT_LINK;
    end else begin
      state_q          <= state_d;
      s_axis_cq_credit <= credit_issue;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // A beat that arrives while the FIFO is full with no pop is dropped, and the error is latched.
      if (s_axis_cq_tvalid && full && !pop) overflow_err <= 1'b1;
      case ({pop, credit_issue})
        2'b10:   credit_pend <= credit_pend + CRED_ONE;
        2'b01:   credit_pend <= credit_pend - CRED_ONE;
        default: credit_pend <= credit_pend;
      endcase
    end
  end

  // Link-state next-state logic.
  // NOTE: state_d gets its default before the case statement, so no latch is
  // inferred on any path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LINK: if (link_up)  state_d = ACTIVE;
      ACTIVE:    if (!link_up) state_d = WAIT_LINK;
      default:   state_d = WAIT_LINK;
    endcase
  end

`ifdef CQ_RXBUF_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;

  // Completed-packet counter: counts each pop that carries tlast, wrapping at 2^32.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n)         pkt_cnt_q <= '0;
    else if (pop && head.tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule
